// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial BCD-to-binary converter.
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;
  localparam logic [BCD_DIGIT_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } bcd_state_e;

  // 10^n, used to check that the binary result width can hold NUM_DIGITS digits
  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 64'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_serial_to_bin_if.sv
// Digit input stream and result output stream of the serial BCD-to-binary converter.
interface bcd_serial_to_bin_if
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 14,
  parameter int NDIG_W = 3
);

  logic                   in_valid;
  logic                   in_ready;
  logic [BCD_DIGIT_W-1:0] in_digit;
  logic                   in_last;
  logic                   out_valid;
  logic                   out_ready;
  logic [BIN_W-1:0]       out_bin;
  logic [NDIG_W-1:0]      out_ndig;
  logic                   out_err;

  modport master (
    output in_valid, in_digit, in_last, out_ready,
    input  in_ready, out_valid, out_bin, out_ndig, out_err
  );

  modport slave (
    input  in_valid, in_digit, in_last, out_ready,
    output in_ready, out_valid, out_bin, out_ndig, out_err
  );

endinterface

// File: rtl/bcd_mac10.sv
// Combinational acc*10 + digit step; digits above 9 contribute zero and raise invalid_o.
module bcd_mac10
  import bcd_pkg::*;
#(
  parameter int BIN_W = 14
) (
  input  logic [BIN_W-1:0]       acc_i,
  input  logic [BCD_DIGIT_W-1:0] digit_i,
  output logic [BIN_W-1:0]       result_o,
  output logic                   invalid_o
);

  logic [BIN_W+3:0]       acc_wide_s;
  logic [BIN_W+3:0]       sum_s;
  logic [BCD_DIGIT_W-1:0] digit_eff_s;
  logic [3:0]             unused_hi_s;

  // Shift-add multiply by ten at four bits of headroom, then drop the headroom
  always_comb begin
    invalid_o   = (digit_i > BCD_MAX);
    if (invalid_o) begin
      digit_eff_s = {BCD_DIGIT_W{1'b0}};
    end else begin
      digit_eff_s = digit_i;
    end
    acc_wide_s  = {4'd0, acc_i};
    sum_s       = (acc_wide_s << 3'd3) + (acc_wide_s << 3'd1)
                + {{BIN_W{1'b0}}, digit_eff_s};
    {unused_hi_s, result_o} = sum_s;
  end

endmodule

// File: rtl/bcd_serial_to_bin.sv
// Accumulates a most-significant-first stream of BCD digits into a binary value,
// flagging invalid digits and numbers longer than NUM_DIGITS.
module bcd_serial_to_bin
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int BIN_W      = 14
) (
  input  logic              clk,
  input  logic              rst,
  bcd_serial_to_bin_if.slave bus
);

  localparam int NDIG_W = $clog2(NUM_DIGITS + 1);
  localparam logic [NDIG_W-1:0] MAX_CNT = NDIG_W'(NUM_DIGITS);

  generate
    if ((64'd1 << BIN_W) <= (pow10(NUM_DIGITS) - 64'd1)) begin : g_width_chk
      $error("bcd_serial_to_bin: BIN_W too narrow for NUM_DIGITS decimal digits");
    end
  endgenerate

  bcd_state_e        state_q, state_d;
  logic [BIN_W-1:0]  acc_q, acc_d;
  logic [NDIG_W-1:0] cnt_q, cnt_d;
  logic              err_q, err_d;

  logic [BIN_W-1:0]  mac_res_s;
  logic              mac_inv_s;
  logic              in_acc_s;
  logic              out_acc_s;
  logic [NDIG_W-1:0] cnt_inc_s;

  bcd_mac10 #(.BIN_W(BIN_W)) u_mac10 (
    .acc_i    (acc_q),
    .digit_i  (bus.in_digit),
    .result_o (mac_res_s),
    .invalid_o(mac_inv_s)
  );

  // Outputs come straight from the state registers
  always_comb begin
    bus.in_ready  = (state_q != DONE);
    bus.out_valid = (state_q == DONE);
    bus.out_bin   = acc_q;
    bus.out_ndig  = cnt_q;
    bus.out_err   = err_q;
  end

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    in_acc_s  = bus.in_valid && (state_q != DONE);
    out_acc_s = bus.out_ready && (state_q == DONE);
    cnt_inc_s = cnt_q + NDIG_W'(1);
    case (state_q)
      ACCUM: begin
        if (in_acc_s) begin
          acc_d = mac_res_s;
          cnt_d = cnt_inc_s;
          err_d = err_q | mac_inv_s;
          if (bus.in_last) begin
            state_d = DONE;
          end else if (cnt_inc_s == MAX_CNT) begin
            // Too many digits: keep the first NUM_DIGITS, swallow the rest
            err_d   = 1'b1;
            state_d = DRAIN;
          end else begin
            state_d = ACCUM;
          end
        end else begin
          state_d = ACCUM;
        end
      end
      DRAIN: begin
        if (in_acc_s && bus.in_last) begin
          state_d = DONE;
        end else begin
          state_d = DRAIN;
        end
      end
      DONE: begin
        if (out_acc_s) begin
          state_d = ACCUM;
          acc_d   = {BIN_W{1'b0}};
          cnt_d   = {NDIG_W{1'b0}};
          err_d   = 1'b0;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = ACCUM;
        acc_d   = {BIN_W{1'b0}};
        cnt_d   = {NDIG_W{1'b0}};
        err_d   = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      acc_q   <= {BIN_W{1'b0}};
      cnt_q   <= {NDIG_W{1'b0}};
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_bcd_serial_to_bin.sv
// Scoreboard bench for bcd_serial_to_bin: a behavioural model predicts each number's
// result when it is driven; the monitor compares on every output handshake.
module tb_bcd_serial_to_bin;
  import bcd_pkg::*;

  localparam int NUM_DIGITS = 4;
  localparam int BIN_W      = 14;
  localparam int NDIG_W     = $clog2(NUM_DIGITS + 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bcd_serial_to_bin_if #(.BIN_W(BIN_W), .NDIG_W(NDIG_W)) bus_if ();

  bcd_serial_to_bin #(.NUM_DIGITS(NUM_DIGITS), .BIN_W(BIN_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  typedef struct {
    int bin;
    int ndig;
    int err;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Compare every accepted result against the oldest prediction
  always @(negedge clk) begin
    if (rst === 1'b0 && bus_if.out_valid === 1'b1 && bus_if.out_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        check_val("sb_unexpected_result", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check_val("out_bin",  32'(bus_if.out_bin),  mon_e.bin);
        check_val("out_ndig", 32'(bus_if.out_ndig), mon_e.ndig);
        check_val("out_err",  32'(bus_if.out_err),  mon_e.err);
      end
    end
  end

  task automatic send_digit(input logic [3:0] d, input bit last);
    int waited;
    waited = 0;
    bus_if.in_valid = 1'b1;
    bus_if.in_digit = d;
    bus_if.in_last  = last;
    @(negedge clk);
    while (bus_if.in_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) begin
      check_val("in_ready_timeout", 32'd0, 32'd1);
      bus_if.in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      if (last) begin
        check_val("latency_out_valid", 32'(bus_if.out_valid), 32'd1);
        check_val("done_in_ready",     32'(bus_if.in_ready),  32'd0);
      end
    end
  endtask

  // Digits packed as hex nibbles, most significant first
  task automatic run_num(input logic [31:0] w, input int len);
    exp_t e;
    int   cnt;
    int   dv;
    e.bin = 0;
    e.err = 0;
    cnt   = 0;
    for (int i = 0; i < len; i++) begin
      dv = int'(w[(len-1-i)*4 +: 4]);
      if (cnt < NUM_DIGITS) begin
        if (dv > 9) begin
          e.err = 1;
          dv    = 0;
        end
        e.bin = e.bin * 10 + dv;
        cnt++;
        if (cnt == NUM_DIGITS && i != len - 1) e.err = 1;
      end
    end
    e.ndig = cnt;
    sb_q.push_back(e);
    for (int i = 0; i < len; i++) begin
      send_digit(w[(len-1-i)*4 +: 4], (i == len - 1));
    end
    bus_if.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 100) check_val("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_in_ready"},  32'(bus_if.in_ready),  32'd1);
    check_val({tag, "_out_valid"}, 32'(bus_if.out_valid), 32'd0);
    check_val({tag, "_out_bin"},   32'(bus_if.out_bin),   32'd0);
    check_val({tag, "_out_ndig"},  32'(bus_if.out_ndig),  32'd0);
    check_val({tag, "_out_err"},   32'(bus_if.out_err),   32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    int          len;
    int          dv;
    rst              = 1'b1;
    bus_if.in_valid  = 1'b0;
    bus_if.in_digit  = 4'd0;
    bus_if.in_last   = 1'b0;
    bus_if.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    run_num(32'h1234, 4);
    run_num(32'h9999, 4);
    run_num(32'h7, 1);
    run_num(32'h5C3, 3);
    run_num(32'h123456, 6);
    wait_drain();

    // Result held while downstream stalls for five cycles
    bus_if.out_ready = 1'b0;
    run_num(32'h42, 2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("hold_out_valid", 32'(bus_if.out_valid), 32'd1);
      check_val("hold_in_ready",  32'(bus_if.in_ready),  32'd0);
      check_val("hold_out_bin",   32'(bus_if.out_bin),   32'd42);
      check_val("hold_out_ndig",  32'(bus_if.out_ndig),  32'd2);
      check_val("hold_out_err",   32'(bus_if.out_err),   32'd0);
      @(posedge clk);
      #1;
    end
    bus_if.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_val("after_hs_in_ready",  32'(bus_if.in_ready),  32'd1);
    check_val("after_hs_out_valid", 32'(bus_if.out_valid), 32'd0);

    // Reset in the middle of a number
    send_digit(4'd8, 1'b0);
    send_digit(4'd7, 1'b0);
    bus_if.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_idle("mid_rst");
    run_num(32'h3, 1);
    wait_drain();

    // Reset while a result is pending discards it
    bus_if.out_ready = 1'b0;
    send_digit(4'd8, 1'b0);
    send_digit(4'd7, 1'b1);
    bus_if.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus_if.out_ready = 1'b1;
    check_idle("done_rst");

    // Random numbers, occasional invalid digits and downstream stalls
    for (int k = 0; k < 16; k++) begin
      len = int'($urandom_range(1, 6));
      w   = 32'd0;
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 7) == 0) dv = int'($urandom_range(10, 15));
        else                           dv = int'($urandom_range(0, 9));
        w = {w[27:0], 4'(dv)};
      end
      bus_if.out_ready = ($urandom_range(0, 2) != 0);
      run_num(w, len);
      if (bus_if.out_ready == 1'b0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
        bus_if.out_ready = 1'b1;
      end
      wait_drain();
    end

    check_val("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
